// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: pc_block inputs, instruction-memory handshake and decoded outputs.
// master = fetch stage, slave = pc_block / control / memory side.
interface instr_fetch_if;
  logic [15:0] pcCur;
  logic        fetchGo;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memAck;
  logic [15:0] memData;
  logic [15:0] instr;
  logic        instrValid;
  logic        pcWrite;
  logic        busy;
  logic [15:0] pcPlus2;
  logic [15:0] immAddr;
  logic [15:0] jcmpImm;
  logic [15:0] jcmpImmLS;
  logic        fetchFault;

  modport master (
    input  pcCur, fetchGo, memAck, memData,
    output memReq, memAddr, instr, instrValid, pcWrite, busy,
           pcPlus2, immAddr, jcmpImm, jcmpImmLS, fetchFault
  );

  modport slave (
    output pcCur, fetchGo, memAck, memData,
    input  memReq, memAddr, instr, instrValid, pcWrite, busy,
           pcPlus2, immAddr, jcmpImm, jcmpImmLS, fetchFault
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/ack read of one word per fetchGo, instruction register and field decode.
// Optional macro FETCH_TIMEOUT_EN adds a REQ timeout with a sticky fetchFault flag.
//
// state | meaning
// IDLE  | waiting for fetchGo
// REQ   | memReq asserted, waiting for memAck
// DONE  | instr newly loaded, instrValid/pcWrite pulse
module instr_fetch #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clock,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instr_q, instr_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.fetchGo) begin
          addr_d  = {bus.pcCur[15:1], 1'b0};
          state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
          fault_d = 1'b0;
`endif
        end
      end
      REQ: begin
        if (bus.memAck) begin
          instr_d = bus.memData;
          state_d = DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        // The cycle that would bring the count to TIMEOUT_CYCLES aborts the fetch.
        else if (cnt_q == CNT_LAST) begin
          instr_d = 16'h0000;
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign bus.fetchFault = fault_q;
`else
  assign bus.fetchFault = 1'b0;
`endif

  assign bus.memReq     = (state_q == REQ);
  assign bus.memAddr    = addr_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.instrValid = (state_q == DONE);
  assign bus.pcWrite    = (state_q == DONE);
  assign bus.instr      = instr_q;

  assign bus.pcPlus2    = addr_q + 16'd2;
  assign bus.immAddr    = {addr_q[15:13], instr_q[11:0], 1'b0};
  assign bus.jcmpImm    = {{8{instr_q[7]}}, instr_q[7:0]};
  assign bus.jcmpImmLS  = {instr_q[7] ? 7'h7F : 7'h00, instr_q[7:0], 1'b0};

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a behavioural fetch/decode model.
// Build with FETCH_TIMEOUT_EN defined to also exercise the timeout path (TIMEOUT_CYCLES=4).
module tb_instr_fetch;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulse_cnt = 0;
  int   exp_pulses = 0;

  always #5 clock = ~clock;

  instr_fetch_if bus_if ();

`ifdef FETCH_TIMEOUT_EN
  instr_fetch #(.TIMEOUT_CYCLES(4)) dut (.clock(clock), .reset(reset), .bus(bus_if));
`else
  instr_fetch dut (.clock(clock), .reset(reset), .bus(bus_if));
`endif

  always @(negedge clock) if (bus_if.pcWrite) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode computed straight from the field definitions.
  function automatic logic [15:0] m_plus2(input logic [15:0] a);
    int v;
    v = (int'(a) + 2) % 65536;
    return v[15:0];
  endfunction

  function automatic logic [15:0] m_imm(input logic [15:0] a, input logic [15:0] d);
    int v;
    v = (int'(a) / 8192) * 8192 + (int'(d) % 4096) * 2;
    return v[15:0];
  endfunction

  function automatic logic [15:0] m_jcmp(input logic [15:0] d);
    int b;
    b = int'(d) % 256;
    if (b >= 128) b = b - 256;
    return b[15:0];
  endfunction

  function automatic logic [15:0] m_jcmp_ls(input logic [15:0] d);
    int v;
    v = (int'(m_jcmp(d)) * 2) % 65536;
    return v[15:0];
  endfunction

  task automatic chk_fields(input string tag, input logic [15:0] a, input logic [15:0] d);
    chk({tag, ".instr"}, bus_if.instr, d);
    chk({tag, ".pcPlus2"}, bus_if.pcPlus2, m_plus2(a));
    chk({tag, ".immAddr"}, bus_if.immAddr, m_imm(a, d));
    chk({tag, ".jcmpImm"}, bus_if.jcmpImm, m_jcmp(d));
    chk({tag, ".jcmpImmLS"}, bus_if.jcmpImmLS, m_jcmp_ls(d));
  endtask

  // Starts and ends just after a negedge with the DUT idle.
  task automatic do_fetch(input logic [15:0] pc, input logic [15:0] data,
                          input int waits, input bit hold);
    logic [15:0] a;
    a = pc & 16'hFFFE;
    bus_if.pcCur   = pc;
    bus_if.fetchGo = 1'b1;
    bus_if.memAck  = 1'b0;
    @(negedge clock);
    if (!hold) bus_if.fetchGo = 1'b0;
    bus_if.pcCur = 16'($urandom);
    for (int i = 0; i <= waits; i++) begin
      chk("req.memReq", bus_if.memReq, 1'b1);
      chk("req.memAddr", bus_if.memAddr, a);
      chk("req.busy", bus_if.busy, 1'b1);
      chk("req.instrValid", bus_if.instrValid, 1'b0);
      chk("req.fetchFault", bus_if.fetchFault, 1'b0);
      bus_if.memAck  = (i == waits);
      bus_if.memData = (i == waits) ? data : 16'($urandom);
      @(negedge clock);
    end
    exp_pulses++;
    chk("done.instrValid", bus_if.instrValid, 1'b1);
    chk("done.pcWrite", bus_if.pcWrite, 1'b1);
    chk("done.memReq", bus_if.memReq, 1'b0);
    chk("done.memAddr", bus_if.memAddr, a);
    chk("done.fetchFault", bus_if.fetchFault, 1'b0);
    chk_fields("done", a, data);
    bus_if.memAck  = 1'b1;
    bus_if.memData = ~data;
    @(negedge clock);
    bus_if.fetchGo = 1'b0;
    chk("idle.busy", bus_if.busy, 1'b0);
    chk("idle.pcWrite", bus_if.pcWrite, 1'b0);
    chk("idle.instrValid", bus_if.instrValid, 1'b0);
    @(negedge clock);
    bus_if.memAck = 1'b0;
    chk("idle2.busy", bus_if.busy, 1'b0);
    chk_fields("idle2", a, data);
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic do_timeout(input logic [15:0] pc);
    bus_if.pcCur   = pc;
    bus_if.fetchGo = 1'b1;
    bus_if.memAck  = 1'b0;
    @(negedge clock);
    bus_if.fetchGo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to.memReq", bus_if.memReq, 1'b1);
      bus_if.memData = 16'($urandom);
      @(negedge clock);
    end
    chk("to.memReq_drop", bus_if.memReq, 1'b0);
    chk("to.busy", bus_if.busy, 1'b0);
    chk("to.fetchFault", bus_if.fetchFault, 1'b1);
    chk("to.instr", bus_if.instr, 16'h0000);
    chk("to.instrValid", bus_if.instrValid, 1'b0);
    @(negedge clock);
    chk("to.fault_sticky", bus_if.fetchFault, 1'b1);
    chk("to.pcWrite", bus_if.pcWrite, 1'b0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.pcCur   = 16'h0000;
    bus_if.fetchGo = 1'b0;
    bus_if.memAck  = 1'b0;
    bus_if.memData = 16'h0000;
    repeat (2) @(negedge clock);
    chk("rst.instr", bus_if.instr, 16'h0000);
    chk("rst.memReq", bus_if.memReq, 1'b0);
    chk("rst.busy", bus_if.busy, 1'b0);
    chk("rst.instrValid", bus_if.instrValid, 1'b0);
    chk("rst.pcWrite", bus_if.pcWrite, 1'b0);
    chk("rst.fetchFault", bus_if.fetchFault, 1'b0);
    chk("rst.memAddr", bus_if.memAddr, 16'h0000);
    chk("rst.pcPlus2", bus_if.pcPlus2, 16'h0002);
    reset = 1'b0;
    @(negedge clock);

    do_fetch(16'h0010, 16'h1234, 0, 1'b0);
    do_fetch(16'h0010, 16'h5A5A, 3, 1'b1);
    do_fetch(16'hE001, 16'h0AFE, 1, 1'b0);
    chk("dec.immAddr", bus_if.immAddr, 16'hF5FC);
    chk("dec.jcmpImm", bus_if.jcmpImm, 16'hFFFE);
    chk("dec.jcmpImmLS", bus_if.jcmpImmLS, 16'hFFFC);
    chk("dec.memAddr", bus_if.memAddr, 16'hE000);
    do_fetch(16'hFFFE, 16'h8081, 0, 1'b0);
    chk("wrap.pcPlus2", bus_if.pcPlus2, 16'h0000);

    for (int n = 0; n < 24; n++)
      do_fetch(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    // Reset in the middle of a transfer, then a stale memAck.
    bus_if.pcCur   = 16'h0010;
    bus_if.fetchGo = 1'b1;
    @(negedge clock);
    bus_if.fetchGo = 1'b0;
    chk("rreq.memReq", bus_if.memReq, 1'b1);
    reset = 1'b1;
    #1;
    chk("rreq.memReq_rst", bus_if.memReq, 1'b0);
    chk("rreq.busy_rst", bus_if.busy, 1'b0);
    chk("rreq.instr_rst", bus_if.instr, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    bus_if.memAck  = 1'b1;
    bus_if.memData = 16'hBEEF;
    repeat (2) @(negedge clock);
    bus_if.memAck = 1'b0;
    chk("rreq.instr_late_ack", bus_if.instr, 16'h0000);
    chk("rreq.busy_late_ack", bus_if.busy, 1'b0);
    chk("rreq.instrValid", bus_if.instrValid, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    do_timeout(16'h0123);
    do_fetch(16'h0040, 16'h4321, 0, 1'b0);
    do_timeout(16'h0200);
    do_fetch(16'h0040, 16'h7E7E, 3, 1'b0);
    chk("to.ack_wins_fault", bus_if.fetchFault, 1'b0);
`endif

    @(negedge clock);
    chk("pcWrite.pulse_count", 32'(pulse_cnt), 32'(exp_pulses));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
